// File: rtl/remote_comm.sv
// Host-side UART command link: sends a 16-bit command as two 8N1 bytes (high byte first) and captures a one-byte reply.
// Optional build macro REMOTE_COMM_STOP_CHECK_EN drops received frames whose stop bit reads 0.
module remote_comm #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        send_cmd,
    output logic        cmd_sent,
    output logic        resp_rdy,
    output logic [7:0]  resp
);

    localparam logic [11:0] BIT_END  = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_END = 12'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {IDLE, TX_HIGH, TX_LOW} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    tx_state_t   tx_state;
    logic [9:0]  tx_shift;
    logic [7:0]  low_byte;
    logic [11:0] tx_baud;
    logic [3:0]  tx_bit;
    logic        sent_pend;
    logic        cmd_accept;
    logic        tx_bit_end;

    rx_state_t   rx_state;
    logic        rx_s1, rx_s2, rx_last;
    logic [11:0] rx_baud;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_bit_end;

    assign cmd_accept = (tx_state == IDLE) && send_cmd;
    assign tx_bit_end = (tx_baud == BIT_END);
    assign rx_bit_end = (rx_baud == BIT_END);

    // TX is registered from tx_shift[0], so the line lags the shifter by one clock;
    // cmd_sent is delayed by the same clock so it rises as the last stop bit ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state  <= IDLE;
            TX        <= 1'b1;
            cmd_sent  <= 1'b0;
            sent_pend <= 1'b0;
            tx_baud   <= '0;
            tx_bit    <= '0;
        end else begin
            sent_pend <= 1'b0;
            if (sent_pend)
                cmd_sent <= 1'b1;
            case (tx_state)
                IDLE: begin
                    TX <= 1'b1;
                    if (send_cmd) begin
                        tx_shift <= {1'b1, cmd[15:8], 1'b0};
                        low_byte <= cmd[7:0];
                        tx_baud  <= '0;
                        tx_bit   <= '0;
                        cmd_sent <= 1'b0;
                        tx_state <= TX_HIGH;
                    end
                end
                TX_HIGH, TX_LOW: begin
                    TX <= tx_shift[0];
                    if (tx_bit_end) begin
                        tx_baud  <= '0;
                        tx_shift <= {1'b1, tx_shift[9:1]};
                        tx_bit   <= tx_bit + 4'd1;
                        if (tx_bit == 4'd9) begin
                            tx_bit <= '0;
                            if (tx_state == TX_HIGH) begin
                                tx_shift <= {1'b1, low_byte, 1'b0};
                                tx_state <= TX_LOW;
                            end else begin
                                sent_pend <= 1'b1;
                                tx_state  <= IDLE;
                            end
                        end
                    end else begin
                        tx_baud <= tx_baud + 12'd1;
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    // Receiver: start edge seen on the synchronized line, confirmed at half a bit,
    // then every later sample lands mid-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_last  <= 1'b1;
            rx_state <= R_IDLE;
            rx_baud  <= '0;
            rx_bit   <= '0;
            resp_rdy <= 1'b0;
            resp     <= 8'h00;
        end else begin
            rx_s1   <= RX;
            rx_s2   <= rx_s1;
            rx_last <= rx_s2;
            if (cmd_accept)
                resp_rdy <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    if (!rx_s2 && rx_last) begin
                        rx_baud  <= '0;
                        rx_state <= R_START;
                    end
                end
                R_START: begin
                    if (rx_baud == HALF_END) begin
                        rx_baud <= '0;
                        if (rx_s2) begin
                            rx_state <= R_IDLE;
                        end else begin
                            resp_rdy <= 1'b0;
                            rx_bit   <= '0;
                            rx_state <= R_DATA;
                        end
                    end else begin
                        rx_baud <= rx_baud + 12'd1;
                    end
                end
                R_DATA: begin
                    if (rx_bit_end) begin
                        rx_baud  <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7)
                            rx_state <= R_STOP;
                    end else begin
                        rx_baud <= rx_baud + 12'd1;
                    end
                end
                R_STOP: begin
                    if (rx_bit_end) begin
                        rx_baud  <= '0;
                        rx_state <= R_IDLE;
`ifdef REMOTE_COMM_STOP_CHECK_EN
                        if (rx_s2) begin
                            resp     <= rx_shift;
                            resp_rdy <= 1'b1;
                        end
`else
                        resp     <= rx_shift;
                        resp_rdy <= 1'b1;
`endif
                    end else begin
                        rx_baud <= rx_baud + 12'd1;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_remote_comm.sv
// Self-checking bench for remote_comm: TX line decoder and response watcher feed scoreboard queues.
module tb_remote_comm;

    localparam int BD = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        send_cmd;
    logic        cmd_sent;
    logic        resp_rdy;
    logic [7:0]  resp;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    bit          mon_en = 1'b1;
    logic        rdy_prev = 1'b0;

    always #5 clk = ~clk;

    remote_comm #(.BAUD_DIV(BD)) dut (
        .clk(clk),
        .rst(rst),
        .RX(RX),
        .TX(TX),
        .cmd(cmd),
        .send_cmd(send_cmd),
        .cmd_sent(cmd_sent),
        .resp_rdy(resp_rdy),
        .resp(resp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Decode the TX line by sampling each bit at its centre.
    initial begin
        logic [7:0] b;
        logic       stop_bit;
        forever begin
            @(negedge clk);
            if (TX === 1'b0) begin
                repeat (BD / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge clk);
                    b[i] = TX;
                end
                repeat (BD) @(negedge clk);
                stop_bit = TX;
                if (mon_en) begin
                    check("tx_stop", 32'(stop_bit), 32'd1);
                    if (tx_q.size() == 0)
                        check("tx_unexpected", 32'(b), 32'h100);
                    else
                        check("tx_byte", 32'(b), 32'(tx_q.pop_front()));
                end
            end
        end
    end

    // Compare resp against the scoreboard on every resp_rdy rise.
    initial begin
        forever begin
            @(negedge clk);
            if (resp_rdy === 1'b1 && !rdy_prev) begin
                if (rx_q.size() == 0)
                    check("rx_unexpected", 32'(resp), 32'h100);
                else
                    check("rx_byte", 32'(resp), 32'(rx_q.pop_front()));
            end
            rdy_prev = (resp_rdy === 1'b1);
        end
    end

    task automatic do_cmd(input logic [15:0] c, input bit busy);
        int cnt;
        bit done;
        @(negedge clk);
        cmd      = c;
        send_cmd = 1'b1;
        tx_q.push_back(c[15:8]);
        tx_q.push_back(c[7:0]);
        @(posedge clk);
        #1;
        send_cmd = 1'b0;
        cmd      = 16'h0000;
        check("tx_idle_at_accept", 32'(TX), 32'd1);
        check("sent_clr", 32'(cmd_sent), 32'd0);
        check("rdy_clr", 32'(resp_rdy), 32'd0);
        cnt  = 0;
        done = 1'b0;
        while (!done && cnt < 30 * BD) begin
            @(posedge clk);
            cnt++;
            #1;
            if (cnt == 1)
                check("tx_start", 32'(TX), 32'd0);
            if (busy && cnt == 100) begin
                cmd      = 16'hFFFF;
                send_cmd = 1'b1;
            end
            if (busy && cnt == 101)
                send_cmd = 1'b0;
            if (cmd_sent)
                done = 1'b1;
        end
        check("sent_latency", 32'(cnt), 32'(20 * BD + 1));
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input bit expect_rx);
        if (expect_rx)
            rx_q.push_back(b);
        @(negedge clk);
        RX = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BD) @(negedge clk);
        end
        RX = stop;
        repeat (BD) @(negedge clk);
        RX = 1'b1;
        repeat (BD) @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        RX       = 1'b1;
        send_cmd = 1'b0;
        cmd      = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx", 32'(TX), 32'd1);
        check("rst_sent", 32'(cmd_sent), 32'd0);
        check("rst_rdy", 32'(resp_rdy), 32'd0);
        check("rst_resp", 32'(resp), 32'h00);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        do_cmd(16'h2001, 1'b0);
        repeat (10) @(posedge clk);
        do_cmd(16'h2001, 1'b1);

        send_frame(8'hA5, 1'b1, 1'b1);
        #1;
        check("rx_rdy_a5", 32'(resp_rdy), 32'd1);
        check("rx_resp_a5", 32'(resp), 32'hA5);
        do_cmd(16'h1234, 1'b0);

        @(negedge clk);
        RX = 1'b0;
        repeat (3) @(negedge clk);
        RX = 1'b1;
        repeat (20 * BD) @(posedge clk);
        #1;
        check("glitch_rdy", 32'(resp_rdy), 32'd0);
        check("glitch_resp", 32'(resp), 32'hA5);

`ifdef REMOTE_COMM_STOP_CHECK_EN
        send_frame(8'h5A, 1'b0, 1'b0);
        repeat (BD) @(posedge clk);
        #1;
        check("frame_err_rdy", 32'(resp_rdy), 32'd0);
        check("frame_err_resp", 32'(resp), 32'hA5);
`else
        send_frame(8'h5A, 1'b0, 1'b1);
        repeat (BD) @(posedge clk);
        #1;
        check("frame_ign_rdy", 32'(resp_rdy), 32'd1);
        check("frame_ign_resp", 32'(resp), 32'h5A);
`endif

        fork
            do_cmd(16'hC3A7, 1'b0);
            begin
                repeat (30) @(posedge clk);
                send_frame(8'h3C, 1'b1, 1'b1);
            end
        join
        repeat (2 * BD) @(posedge clk);
        #1;
        check("dup_rdy", 32'(resp_rdy), 32'd1);
        check("dup_resp", 32'(resp), 32'h3C);
        check("tx_q_empty", 32'(tx_q.size()), 32'd0);
        check("rx_q_empty", 32'(rx_q.size()), 32'd0);

        mon_en = 1'b0;
        @(negedge clk);
        cmd      = 16'h0000;
        send_cmd = 1'b1;
        RX       = 1'b0;
        @(posedge clk);
        #1;
        send_cmd = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("mid_tx_low", 32'(TX), 32'd0);
        rst = 1'b1;
        RX  = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_tx", 32'(TX), 32'd1);
        check("mid_rst_sent", 32'(cmd_sent), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20 * BD) @(posedge clk);
        #1;
        check("mid_rst_tx_idle", 32'(TX), 32'd1);
        check("mid_rst_rdy", 32'(resp_rdy), 32'd0);
        check("mid_rst_resp", 32'(resp), 32'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
